stm32_transfer_scheduler: RTL

Sequences all sample and status transfers on the 4-bit STM32 nibble bus. It decodes each command nibble and decouples both IQ directions from bus timing with two small FIFOs. RX IQ samples from the DDC are queued, then streamed out a frame at a time when the STM32 asks for them. TX IQ frames from the STM32 are queued, then released to the DUC/DAC path on its sample strobe.

---
 rtl/stm32_transfer_scheduler_pkg.sv | 35 +++
 rtl/stm32_transfer_scheduler_if.sv | 11 +
 rtl/stm32_transfer_scheduler_sync_fifo.sv | 55 +++++
 rtl/stm32_transfer_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/stm32_transfer_scheduler_pkg.sv
// Shared definitions for the STM32 nibble-bus transfer scheduler.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package stm32_if_pkg;

  // Command nibbles sampled on the data_sync cycle.
  localparam logic [3:0] CMD_STATUS = 4'd2;
  localparam logic [3:0] CMD_TX_IQ  = 4'd3;
  localparam logic [3:0] CMD_RX_IQ  = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STATUS   = 2'd1,
    ST_TX_FRAME = 2'd2,
    ST_RX_FRAME = 2'd3
  } state_e;

  // One IQ frame = {Q, I} = 32 bits = 8 nibbles on the bus.
  localparam int NIBBLES_PER_FRAME = 8;

  // Status nibble bit positions.
  localparam int STAT_RX_OVF   = 3;
  localparam int STAT_TX_UDF   = 2;
  localparam int STAT_RX_EMPTY = 1;
  localparam int STAT_ADC_OTR  = 0;

  // Nibble idx of a {Q,I} frame, MSB-first: idx 0 is Q[15:12], idx 7 is I[3:0].
  function automatic logic [3:0] frame_nibble(input logic [31:0] frame,
                                              input logic [2:0]  idx);
    logic [31:0] shifted;
    shifted = frame >> {3'd7 - idx, 2'b00};
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/stm32_transfer_scheduler_if.sv
// Nibble bus between the STM32 and the transfer scheduler.
// Latency: n/a (wires only). Ports: data_sync/data_in from STM32, data_out to STM32.
// Backpressure: none; the STM32 paces every transfer with data_sync.
interface stm32_transfer_scheduler_if;
  logic       data_sync;
  logic [3:0] data_in;
  logic [3:0] data_out;

  modport master (output data_sync, output data_in, input data_out);
  modport slave  (input data_sync, input data_in, output data_out);
endinterface

// File: rtl/stm32_transfer_scheduler_sync_fifo.sv
// Single-clock FIFO with occupancy count; head is visible combinationally.
// Latency: push visible at head/count the cycle after the push edge.
// Backpressure: none; push into full is dropped unless a pop lands on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];

  // Pop is evaluated first, so a full FIFO still accepts a same-edge push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/stm32_transfer_scheduler.sv
// Decodes STM32 nibble-bus commands; streams RX IQ out, collects TX IQ in, reports status.
// Latency: nibble n of a frame registered S+1+n after sync at S; tx_i/tx_q 1 cycle after tx_strobe.
// Backpressure: none; RX overflow drops the new sample (sticky flag), TX overflow drops silently.
// Ports: clk_in/reset_n, bus (slave nibble bus), rx_i/rx_q/rx_valid from DDC, adc_otr,
//        tx_strobe from DUC, tx_i/tx_q to DUC, rx_level = RX FIFO occupancy.
module stm32_transfer_scheduler
  import stm32_if_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk_in,
  input  logic                         reset_n,
  stm32_transfer_scheduler_if.slave    bus,
  input  logic signed [15:0]           rx_i,
  input  logic signed [15:0]           rx_q,
  input  logic                         rx_valid,
  input  logic                         adc_otr,
  input  logic                         tx_strobe,
  output logic signed [15:0]           tx_i,
  output logic signed [15:0]           tx_q,
  output logic [$clog2(FIFO_DEPTH):0]  rx_level
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e      state;
  logic [2:0]  nib_cnt;
  logic [31:0] rx_frame;
  logic [27:0] tx_shift;
  logic [3:0]  data_out_q;
  logic        rx_overflow;
  logic        tx_underflow;

  logic        rx_pop;
  logic [31:0] rx_head;
  logic        rx_full;
  logic        rx_empty;
  logic [CW-1:0] rx_count;

  logic        tx_push;
  logic [31:0] tx_push_dat;
  logic [31:0] tx_head;
  logic        tx_empty;
  logic        tx_full_unused;
  logic [CW-1:0] tx_count_unused;

  logic        last_nib;
  logic        status_drive;
  logic        rx_ovf_evt;
  logic        tx_udf_evt;
  logic [3:0]  status_nib;

  assign bus.data_out = data_out_q;
  assign rx_level     = rx_count;

  assign last_nib = (nib_cnt == 3'(NIBBLES_PER_FRAME - 1));

  // The RX head leaves the FIFO on the sync edge itself, so the frame owns it
  // even if the frame is later aborted.
  assign rx_pop = bus.data_sync && (bus.data_in == CMD_RX_IQ);

  // A new sync always wins over the last nibble, which discards a partial TX frame.
  assign tx_push     = (state == ST_TX_FRAME) && !bus.data_sync && last_nib;
  assign tx_push_dat = {tx_shift, bus.data_in};

  // A same-edge RX pop frees a slot, so a full FIFO only overflows without one.
  assign rx_ovf_evt   = rx_valid && rx_full && !rx_pop;
  assign tx_udf_evt   = tx_strobe && tx_empty;
  assign status_drive = (state == ST_STATUS) && !bus.data_sync;

  always_comb begin
    status_nib                = '0;
    status_nib[STAT_RX_OVF]   = rx_overflow;
    status_nib[STAT_TX_UDF]   = tx_underflow;
    status_nib[STAT_RX_EMPTY] = rx_empty;
    status_nib[STAT_ADC_OTR]  = adc_otr;
  end

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .push     (rx_valid),
    .push_dat ({rx_q, rx_i}),
    .pop      (rx_pop),
    .head_dat (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .push     (tx_push),
    .push_dat (tx_push_dat),
    .pop      (tx_strobe),
    .head_dat (tx_head),
    .full     (tx_full_unused),
    .empty    (tx_empty),
    .count    (tx_count_unused)
  );

  // Sticky flags: cleared by the edge that drives the status nibble, but an
  // event on that same edge keeps the bit set.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      rx_overflow  <= (rx_overflow  && !status_drive) || rx_ovf_evt;
      tx_underflow <= (tx_underflow && !status_drive) || tx_udf_evt;
    end
  end

  // TX sample path: on an empty FIFO the outputs hold their last value.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      tx_i <= '0;
      tx_q <= '0;
    end else if (tx_strobe && !tx_empty) begin
      tx_q <= tx_head[31:16];
      tx_i <= tx_head[15:0];
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      nib_cnt    <= '0;
      rx_frame   <= '0;
      tx_shift   <= '0;
      data_out_q <= '0;
    end else if (bus.data_sync) begin
      nib_cnt <= '0;
      case (bus.data_in)
        CMD_STATUS: state <= ST_STATUS;
        CMD_TX_IQ:  state <= ST_TX_FRAME;
        CMD_RX_IQ: begin
          state    <= ST_RX_FRAME;
          rx_frame <= rx_empty ? '0 : rx_head;
        end
        default:    state <= ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_STATUS: begin
          data_out_q <= status_nib;
          state      <= ST_IDLE;
        end
        ST_RX_FRAME: begin
          data_out_q <= frame_nibble(rx_frame, nib_cnt);
          nib_cnt    <= nib_cnt + 1'b1;
          if (last_nib) state <= ST_IDLE;
        end
        ST_TX_FRAME: begin
          tx_shift <= {tx_shift[23:0], bus.data_in};
          nib_cnt  <= nib_cnt + 1'b1;
          if (last_nib) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
